// File: rtl/rca_pipe_pkg.sv
`default_nettype none
// ============================================================================
// rca_pipe_pkg : shared constants and helpers for the pipelined add/sub block
// Rev 1.0
// ============================================================================
package rca_pipe_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit stages_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rca_chunk.sv
`default_nettype none
// ============================================================================
// rca_chunk : combinational CW-bit ripple-carry adder built from full-adder cells
// Rev 1.0
// ============================================================================
module rca_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] sum,
  output logic          cout
);

  logic [CW:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CW];

endmodule
`default_nettype wire

// File: rtl/rca_pipe.sv
`default_nettype none
// ============================================================================
// rca_pipe : WIDTH-bit adder/subtractor, one carry chunk per pipeline stage
// Rev 1.0
// ============================================================================
module rca_pipe
  import rca_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!stages_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("rca_pipe: WIDTH must be a positive multiple of STAGES");
  end

  logic             adv;
  logic             accept;
  logic [WIDTH-1:0] yi;
  logic             ci;

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             ovf_q;

  // One global stall: the whole pipe moves only when the output slot frees up.
  assign adv    = !out_valid_q || out_ready;
  assign accept = in_valid && adv;
  assign yi     = (op == OP_SUB) ? ~y : y;
  assign ci     = (op == OP_SUB) ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // RW: operand bits still unconsumed on entry to this stage (chunk k and above)
    localparam int RW = WIDTH - k * CW;
    localparam int AW = (k + 1) * CW;

    logic [RW-1:0] rx;
    logic [RW-1:0] ry;
    logic          c_in;
    logic          v_in;
    logic [CW-1:0] sum;
    logic          cout;
    logic [AW-1:0] acc;

    if (k == 0) begin : g_src
      assign rx   = x;
      assign ry   = yi;
      assign c_in = ci;
      assign v_in = accept;
      assign acc  = sum;
    end else begin : g_src
      assign rx   = g_stage[k-1].g_fwd.rx_q;
      assign ry   = g_stage[k-1].g_fwd.ry_q;
      assign c_in = g_stage[k-1].g_fwd.c_q;
      assign v_in = g_stage[k-1].g_fwd.vld_q;
      assign acc  = {sum, g_stage[k-1].g_fwd.acc_q};
    end

    rca_chunk #(
      .CW (CW)
    ) u_chunk (
      .a    (rx[CW-1:0]),
      .b    (ry[CW-1:0]),
      .ci   (c_in),
      .sum  (sum),
      .cout (cout)
    );

    if (k < STAGES - 1) begin : g_fwd
      logic             vld_q;
      logic             c_q;
      logic [AW-1:0]    acc_q;
      logic [RW-CW-1:0] rx_q;
      logic [RW-CW-1:0] ry_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= 1'b0;
          c_q   <= 1'b0;
          acc_q <= '0;
          rx_q  <= '0;
          ry_q  <= '0;
        end else if (adv) begin
          vld_q <= v_in;
          c_q   <= cout;
          acc_q <= acc;
          rx_q  <= rx[RW-1:CW];
          ry_q  <= ry[RW-1:CW];
        end
      end
    end else begin : g_out
      // The top chunk still carries the sign bits of x and yi here.
      logic ovf_d;

      assign ovf_d = (rx[CW-1] == ry[CW-1]) && (sum[CW-1] != rx[CW-1]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          s_q         <= '0;
          co_q        <= 1'b0;
          ovf_q       <= 1'b0;
        end else if (adv) begin
          out_valid_q <= v_in;
          s_q         <= acc;
          co_q        <= cout;
          ovf_q       <= ovf_d;
        end
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: doc/rca_pipe.md
Name: rca_pipe

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor. It replaces the fixed 16-bit combinational adder with a WIDTH-bit datapath that is split into STAGES carry-chained chunks.
- Each chunk has one register stage. Input and output use valid/ready handshakes with full backpressure.
- Adds a subtract mode and a signed-overflow flag.
- Sits in the arithmetic datapath; it feeds downstream accumulate and compare logic.

Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages and carry chunks; 1..WIDTH. Chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- cin  input  1  carry-in (ADD) or borrow-in (SUB)
- op  input  1  0 = ADD, 1 = SUB
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- s  output  WIDTH  sum or difference
- co  output  1  carry-out; in SUB, 1 means no borrow
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset (async assert; release is synchronised by the system):
  - All stage valid bits, s, co and ovf are cleared to 0 immediately.
  - in_ready = 1 while rst is low.
  - Operand skew and sum registers are cleared to 0.
- Arithmetic per accepted beat:
  - ADD: {co,s} = x + y + cin.
  - SUB: yi = ~y, ci = ~cin, then {co,s} = x + yi + ci. This gives x - y - cin; co = 0 indicates a borrow.
  - ovf = (x[W-1] == yi[W-1]) && (s[W-1] != x[W-1]), where yi = y in ADD mode.
- Pipeline structure:
  - Stage k (0..STAGES-1) adds operand chunk k with the carry registered from stage k-1. Stage 0 uses ci.
  - Chunk k operands enter via a k-deep skew register.
  - Completed lower sum chunks travel forward with the beat.
  - The sign bits of x and yi are carried forward for the ovf computation in the last stage.
- Handshake:
  - adv = !out_valid || out_ready. This is a global stall.
  - in_ready = adv.
  - A beat is accepted when in_valid && in_ready.
  - When adv = 1, every stage shifts one step; a non-accepted cycle injects a bubble (valid = 0).
  - When adv = 0, all stage registers hold.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall. Throughput is one beat per cycle.
- Output stability: s, co, ovf and out_valid hold constant while out_valid && !out_ready.
- Ordering: strictly in order. No beat is dropped or duplicated.
- Simultaneous events: when out_valid && out_ready && in_valid occur together, the output pops and the input is accepted in the same cycle.
- STAGES = 1: a single registered adder; latency 1.
- Reset mid-operation: all in-flight beats are discarded. No stale result appears after reset release.
- Boundary values:
  - Carry out of the full-width sum (e.g. all-ones + 1) wraps s to 0 with co = 1.
  - Carry out of chunk k into chunk k+1 propagates correctly across the stage boundary.

Decomposition:
- Package rca_pipe_pkg:
  - OP_ADD/OP_SUB constants.
  - A function computing CW.
  - An elaboration check that WIDTH % STAGES == 0.
- Sub-module rca_chunk: combinational CW-bit ripple-carry adder built from full-adder cells.
  - Ports: a, b, ci, sum, cout.
  - rca_pipe instantiates it once per stage in a generate loop.

Test Plan (WIDTH=32, STAGES=4, unless noted):
- Reset: assert rst mid-cycle → out_valid, s, co, ovf = 0 without waiting for a clock edge; in_ready = 1 after release.
- ADD 0xFFFFFFFF + 0x00000001, cin = 0 → exactly 4 cycles later out_valid = 1, s = 0x00000000, co = 1, ovf = 0.
- SUB 0x00000005 - 0x00000007, cin = 0 → s = 0xFFFFFFFE, co = 0 (borrow), ovf = 0. SUB 0x80000000 - 0x00000001 → s = 0x7FFFFFFF, co = 1, ovf = 1.
- ADD 0x7FFFFFFF + 0x00000001 → s = 0x80000000, ovf = 1, co = 0. ADD 0x0000FFFF + 0x00000001 → s = 0x00010000, checking carry across a chunk boundary.
- Eight back-to-back random beats with out_ready = 0 on cycles 3–5 → in_ready = 0 during the stall, outputs hold stable, and all 8 results match the reference model in order. Repeat with STAGES = 1 and STAGES = 8.
- Assert rst with 3 beats in flight → out_valid = 0 immediately, and no output appears after release until new beats are sent.
